// File: rtl/skin_bin_pkg.sv
// Shared constants for the Cb/Cr skin binariser: threshold register map and
// power-up window defaults.
package skin_bin_pkg;

  localparam logic [1:0] CFG_CB_MIN = 2'd0;
  localparam logic [1:0] CFG_CB_MAX = 2'd1;
  localparam logic [1:0] CFG_CR_MIN = 2'd2;
  localparam logic [1:0] CFG_CR_MAX = 2'd3;

  localparam int unsigned DEF_CB_MIN = 77;
  localparam int unsigned DEF_CB_MAX = 127;
  localparam int unsigned DEF_CR_MIN = 133;
  localparam int unsigned DEF_CR_MAX = 173;

  localparam int unsigned NUM_THR = 4;

  function automatic int unsigned def_thresh(input logic [1:0] addr);
    int unsigned val;
    case (addr)
      CFG_CB_MIN: val = DEF_CB_MIN;
      CFG_CB_MAX: val = DEF_CB_MAX;
      CFG_CR_MIN: val = DEF_CR_MIN;
      default:    val = DEF_CR_MAX;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/skin_window_cmp.sv
// Registered inclusive window compare lo <= x <= hi (unsigned). An inverted
// window (lo > hi) can never satisfy both halves, so it never matches.
module skin_window_cmp #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  output logic              in_win
);

  logic ge_lo_q, ge_lo_d;
  logic le_hi_q, le_hi_d;

  always_comb begin
    ge_lo_d = (x >= lo);
    le_hi_d = (x <= hi);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ge_lo_q <= 1'b0;
      le_hi_q <= 1'b0;
    end else begin
      ge_lo_q <= ge_lo_d;
      le_hi_q <= le_hi_d;
    end
  end

  assign in_win = ge_lo_q & le_hi_q;

endmodule

// File: rtl/skin_bin_frame.sv
// Cb/Cr skin binariser: 2-cycle mask pipeline with matched syncs, shadowed
// thresholds committed on the input frame edge, and a per-frame skin counter.
module skin_bin_frame
  import skin_bin_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OUT_W       = 8,
  parameter int CNT_W       = 22,
  parameter int VS_ACT_HIGH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] cb,
  input  logic [DATA_W-1:0] cr,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  output logic              cfg_pending,
  output logic [OUT_W-1:0]  bin_out,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [CNT_W-1:0]  skin_count,
  output logic              count_valid
);

  localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};

  // Threshold registers: shadow takes writes, active drives the comparators.
  logic [DATA_W-1:0] sh_q  [NUM_THR];
  logic [DATA_W-1:0] sh_d  [NUM_THR];
  logic [DATA_W-1:0] act_q [NUM_THR];
  logic [DATA_W-1:0] act_d [NUM_THR];
  logic              pend_q, pend_d;

  logic vs_act_in, vs_in_prev_q, frame_in;
  logic vs_act_out, vs_out_prev_q, frame_out;

  logic cb_ok, cr_ok;
  logic de_s1_q, hs_s1_q, vs_s1_q;
  logic match_s2_q, match_s2_d;
  logic [OUT_W-1:0] bin_q, bin_d;
  logic de_out_q, hs_out_q, vs_out_q;

  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] skin_count_q, skin_count_d;
  logic             count_valid_q, count_valid_d;

  assign vs_act_in  = (VS_ACT_HIGH != 0) ? vsync_in : ~vsync_in;
  assign frame_in   = vs_act_in & ~vs_in_prev_q;
  assign vs_act_out = (VS_ACT_HIGH != 0) ? vs_out_q : ~vs_out_q;
  assign frame_out  = vs_act_out & ~vs_out_prev_q;

  // A write coincident with the commit lands in shadow only, so the commit
  // copies the pre-write shadow and the write stays pending.
  always_comb begin
    sh_d   = sh_q;
    act_d  = act_q;
    pend_d = pend_q;
    if (frame_in) begin
      act_d  = sh_q;
      pend_d = 1'b0;
    end
    if (cfg_wr) begin
      sh_d[cfg_addr] = cfg_data;
      pend_d         = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_THR; i++) begin
        sh_q[i]  <= DATA_W'(def_thresh(2'(i)));
        act_q[i] <= DATA_W'(def_thresh(2'(i)));
      end
      pend_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      act_q  <= act_d;
      pend_q <= pend_d;
    end
  end

  skin_window_cmp #(.DATA_W(DATA_W)) u_cb_cmp (
    .clk    (clk),
    .rst_n  (rst_n),
    .x      (cb),
    .lo     (act_q[CFG_CB_MIN]),
    .hi     (act_q[CFG_CB_MAX]),
    .in_win (cb_ok)
  );

  skin_window_cmp #(.DATA_W(DATA_W)) u_cr_cmp (
    .clk    (clk),
    .rst_n  (rst_n),
    .x      (cr),
    .lo     (act_q[CFG_CR_MIN]),
    .hi     (act_q[CFG_CR_MAX]),
    .in_win (cr_ok)
  );

  always_comb begin
    match_s2_d = cb_ok & cr_ok & de_s1_q;
    bin_d      = {OUT_W{match_s2_d}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_s1_q       <= 1'b0;
      hs_s1_q       <= 1'b0;
      vs_s1_q       <= 1'b0;
      match_s2_q    <= 1'b0;
      bin_q         <= '0;
      de_out_q      <= 1'b0;
      hs_out_q      <= 1'b0;
      vs_out_q      <= 1'b0;
      vs_in_prev_q  <= 1'b0;
      vs_out_prev_q <= 1'b0;
    end else begin
      de_s1_q       <= de_in;
      hs_s1_q       <= hsync_in;
      vs_s1_q       <= vsync_in;
      match_s2_q    <= match_s2_d;
      bin_q         <= bin_d;
      de_out_q      <= de_s1_q;
      hs_out_q      <= hs_s1_q;
      vs_out_q      <= vs_s1_q;
      vs_in_prev_q  <= vs_act_in;
      vs_out_prev_q <= vs_act_out;
    end
  end

  // A pixel matching on the report cycle opens the new frame's tally.
  always_comb begin
    acc_d         = acc_q;
    skin_count_d  = skin_count_q;
    count_valid_d = 1'b0;
    if (frame_out) begin
      skin_count_d  = acc_q;
      count_valid_d = 1'b1;
      acc_d         = CNT_W'(match_s2_q);
    end else if (match_s2_q && (acc_q != ACC_MAX)) begin
      acc_d = acc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q         <= '0;
      skin_count_q  <= '0;
      count_valid_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      skin_count_q  <= skin_count_d;
      count_valid_q <= count_valid_d;
    end
  end

  assign cfg_pending = pend_q;
  assign bin_out     = bin_q;
  assign de_out      = de_out_q;
  assign hsync_out   = hs_out_q;
  assign vsync_out   = vs_out_q;
  assign skin_count  = skin_count_q;
  assign count_valid = count_valid_q;

endmodule

// File: tb/tb_skin_bin_frame.sv
// Directed bench for skin_bin_frame: a default-width instance and a CNT_W=4
// instance share all inputs so counter saturation is seen alongside exact counts.
module tb_skin_bin_frame;
  import skin_bin_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cb = '0, cr = '0;
  logic       de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;

  logic        pend_a, de_a, hs_a, vs_a, cv_a;
  logic [7:0]  bin_a;
  logic [21:0] cnt_a;
  logic        pend_b, de_b, hs_b, vs_b, cv_b;
  logic [7:0]  bin_b;
  logic [3:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  skin_bin_frame dut (
    .clk(clk), .rst_n(rst_n), .cb(cb), .cr(cr), .de_in(de_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_pending(pend_a),
    .bin_out(bin_a), .de_out(de_a), .hsync_out(hs_a), .vsync_out(vs_a),
    .skin_count(cnt_a), .count_valid(cv_a)
  );

  skin_bin_frame #(.CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .cb(cb), .cr(cr), .de_in(de_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_pending(pend_b),
    .bin_out(bin_b), .de_out(de_b), .hsync_out(hs_b), .vsync_out(vs_b),
    .skin_count(cnt_b), .count_valid(cv_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px_check(input logic [7:0] cb_v, input logic [7:0] cr_v,
                          input logic de_v, input logic [7:0] exp);
    cb = cb_v; cr = cr_v; de_in = de_v;
    tick();
    de_in = 1'b0;
    chk("bin_lat1", bin_a, 8'h00);
    tick();
    chk("bin_out", bin_a, exp);
    chk("de_out", de_a, de_v);
    $display("px cb=%0d cr=%0d de=%0d -> bin=%02h", cb_v, cr_v, de_v, bin_a);
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
    cfg_wr = 1'b1; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_wr = 1'b0;
    $display("cfg addr=%0d data=%0d pending=%0d", addr, data, pend_a);
  endtask

  task automatic frame_pulse();
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    repeat (4) tick();
    $display("frame edge");
  endtask

  task automatic stream(input int total, input int nskin, input logic [7:0] skin_cr);
    for (int i = 0; i < total; i++) begin
      cb = 8'd100;
      cr = (i < nskin) ? skin_cr : 8'd100;
      de_in = 1'b1;
      tick();
    end
    de_in = 1'b0;
    repeat (3) tick();
    $display("stream total=%0d skin=%0d", total, nskin);
  endtask

  task automatic frame_check(input int exp_a, input int exp_b);
    vsync_in = 1'b1;
    tick();
    vsync_in = 1'b0;
    chk("cv_k0", cv_a, 1'b0);
    tick();
    chk("cv_k1", cv_a, 1'b0);
    tick();
    chk("cv_k2", cv_a, 1'b1);
    chk("cv_small", cv_b, 1'b1);
    chk("skin_count", cnt_a, exp_a);
    chk("skin_count_sat", cnt_b, exp_b);
    tick();
    chk("cv_pulse_end", cv_a, 1'b0);
    $display("frame report count=%0d small=%0d", cnt_a, cnt_b);
  endtask

  logic [7:0] t_cb  [9] = '{8'd100, 8'd20,  8'd120, 8'd20,  8'd77,  8'd127, 8'd76,  8'd100, 8'd100};
  logic [7:0] t_cr  [9] = '{8'd150, 8'd200, 8'd140, 8'd140, 8'd133, 8'd173, 8'd150, 8'd174, 8'd150};
  logic       t_de  [9] = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0};
  logic [7:0] t_exp [9] = '{8'hFF,  8'h00,  8'hFF,  8'h00,  8'hFF,  8'hFF,  8'h00,  8'h00,  8'h00};

  initial begin
    // Reset with live skin input and syncs: outputs must stay cleared.
    rst_n = 1'b0; cb = 8'd100; cr = 8'd150; de_in = 1'b1; hsync_in = 1'b1;
    repeat (3) tick();
    chk("rst_bin", bin_a, 8'h00);
    chk("rst_de", de_a, 1'b0);
    chk("rst_hs", hs_a, 1'b0);
    chk("rst_vs", vs_a, 1'b0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_cv", cv_a, 1'b0);
    chk("rst_pend", pend_a, 1'b0);
    de_in = 1'b0; hsync_in = 1'b0; rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) px_check(t_cb[i], t_cr[i], t_de[i], t_exp[i]);

    hsync_in = 1'b1;
    tick();
    hsync_in = 1'b0;
    chk("hs_d1", hs_a, 1'b0);
    tick();
    chk("hs_d2", hs_a, 1'b1);
    tick();
    chk("hs_d3", hs_a, 1'b0);

    // Shadowed threshold write only takes effect at the next frame edge.
    cfg_write(CFG_CR_MIN, 8'd150);
    chk("pend_set", pend_a, 1'b1);
    px_check(8'd100, 8'd140, 1'b1, 8'hFF);
    frame_pulse();
    chk("pend_clr", pend_a, 1'b0);
    px_check(8'd100, 8'd140, 1'b1, 8'h00);
    px_check(8'd100, 8'd150, 1'b1, 8'hFF);

    frame_pulse();
    stream(1000, 300, 8'd160);
    frame_check(300, 15);
    stream(20, 20, 8'd160);
    frame_check(20, 15);

    // Write coincident with the frame edge: old shadow commits, write stays pending.
    cfg_write(CFG_CB_MAX, 8'd90);
    chk("pend_cbmax", pend_a, 1'b1);
    cfg_wr = 1'b1; cfg_addr = CFG_CB_MIN; cfg_data = 8'd110; vsync_in = 1'b1;
    tick();
    cfg_wr = 1'b0; vsync_in = 1'b0;
    tick();
    chk("pend_coinc", pend_a, 1'b1);
    px_check(8'd80, 8'd160, 1'b1, 8'hFF);
    px_check(8'd100, 8'd160, 1'b1, 8'h00);
    frame_pulse();
    chk("pend_coinc_clr", pend_a, 1'b0);
    px_check(8'd110, 8'd160, 1'b1, 8'h00);
    px_check(8'd90, 8'd160, 1'b1, 8'h00);

    // Mid-frame reset drops pending writes, accumulator and non-default thresholds.
    cfg_write(CFG_CB_MIN, 8'd77);
    frame_pulse();
    stream(5, 5, 8'd160);
    cfg_write(CFG_CR_MIN, 8'd200);
    chk("pend_prerst", pend_a, 1'b1);
    rst_n = 1'b0; cb = 8'd100; cr = 8'd140; de_in = 1'b1;
    tick();
    chk("mrst_bin", bin_a, 8'h00);
    chk("mrst_de", de_a, 1'b0);
    chk("mrst_pend", pend_a, 1'b0);
    chk("mrst_cnt", cnt_a, 0);
    chk("mrst_cv", cv_a, 1'b0);
    rst_n = 1'b1; de_in = 1'b0;
    tick();
    px_check(8'd100, 8'd140, 1'b1, 8'hFF);
    stream(7, 6, 8'd140);
    frame_check(7, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
